store_m: RTL and testbench

- Tile-to-DRAM writer: the store-side counterpart of the tile loader.
- Accepts TILE_WIDTH-bit tiles from the execution unit and unpacks them into bytes, MSB byte first.
- Writes bytes sequentially to byte-addressed memory through a registered write port, starting at dram_addr, for exactly `length` bytes.
- Padding bytes in the final tile are discarded, never written.

---
 rtl/tinyml_pkg.sv | 20 ++
 rtl/store_m_if.sv | 32 +++
 rtl/store_m_serializer.sv | 32 +++
 rtl/store_m.sv | 121 ++++++++++++
 tb/tb_store_m.sv | 302 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/tinyml_pkg.sv
// Shared widths, store-FSM state type and helpers for the tinyml memory movers.
package tinyml_pkg;

  localparam int unsigned MEM_ADDR_WIDTH = 24;
  localparam int unsigned LENGTH_WIDTH   = 20;
  localparam int unsigned BYTE_WIDTH     = 8;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_TILE = 2'd1,
    WRITING   = 2'd2,
    DONE      = 2'd3
  } store_state_e;

  // Counter width that stays at least one bit for single-byte tiles.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/store_m_if.sv
// Command, tile and memory-write signals of the tile store block.
interface store_m_if
  import tinyml_pkg::*;
#(
  parameter int unsigned TILE_WIDTH = 256,
  parameter int unsigned ADDR_WIDTH = MEM_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = BYTE_WIDTH
);

  logic                    valid_in;
  logic [ADDR_WIDTH-1:0]   dram_addr;
  logic [LENGTH_WIDTH-1:0] length;
  logic [TILE_WIDTH-1:0]   tile_in;
  logic                    tile_valid_in;
  logic                    tile_ready;
  logic                    mem_we;
  logic [ADDR_WIDTH-1:0]   mem_addr;
  logic [DATA_WIDTH-1:0]   mem_din;
  logic                    busy;
  logic                    valid_out;

  modport master (
    output valid_in, dram_addr, length, tile_in, tile_valid_in,
    input  tile_ready, mem_we, mem_addr, mem_din, busy, valid_out
  );

  modport slave (
    input  valid_in, dram_addr, length, tile_in, tile_valid_in,
    output tile_ready, mem_we, mem_addr, mem_din, busy, valid_out
  );

endinterface

// File: rtl/store_m_serializer.sv
// Holds one accepted tile and presents its bytes MSB-first by index.
module tile_byte_serializer
  import tinyml_pkg::*;
#(
  parameter  int unsigned TILE_WIDTH = 256,
  localparam int unsigned NUM_BYTES  = TILE_WIDTH / BYTE_WIDTH,
  localparam int unsigned CNT_W      = cnt_width(NUM_BYTES)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [TILE_WIDTH-1:0] tile_in,
  input  logic [CNT_W-1:0]      byte_cnt,
  output logic [BYTE_WIDTH-1:0] byte_c,
  output logic                  last_byte_c
);

  logic [TILE_WIDTH-1:0] tile_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tile_q <= '0;
    end else if (load) begin
      tile_q <= tile_in;
    end
  end

  // Byte 0 sits in the top byte lane of the tile.
  assign byte_c      = BYTE_WIDTH'(tile_q >> (BYTE_WIDTH * (NUM_BYTES - 1 - 32'(byte_cnt))));
  assign last_byte_c = (byte_cnt == CNT_W'(NUM_BYTES - 1));

endmodule

// File: rtl/store_m.sv
// Tile-to-DRAM writer: unpacks tiles MSB byte first into sequential byte writes.
module store_m
  import tinyml_pkg::*;
#(
  parameter int unsigned TILE_WIDTH = 256,
  parameter int unsigned DATA_WIDTH = BYTE_WIDTH,
  parameter int unsigned ADDR_WIDTH = MEM_ADDR_WIDTH
) (
  input logic      clk,
  input logic      rst,
  store_m_if.slave bus
);

  localparam int unsigned NUM_BYTES = TILE_WIDTH / BYTE_WIDTH;
  localparam int unsigned CNT_W     = cnt_width(NUM_BYTES);

  store_state_e            state_q, state_d;
  logic [ADDR_WIDTH-1:0]   cur_addr_q, cur_addr_d;
  logic [LENGTH_WIDTH-1:0] bytes_left_q, bytes_left_d;
  logic [CNT_W-1:0]        byte_cnt_q, byte_cnt_d;
  logic                    mem_we_q, mem_we_d;
  logic [ADDR_WIDTH-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0]   mem_din_q, mem_din_d;
  logic                    valid_out_q, valid_out_d;
  logic                    busy_q, busy_d;
  logic                    load_c;
  logic [BYTE_WIDTH-1:0]   byte_c;
  logic                    last_byte_c;

  tile_byte_serializer #(.TILE_WIDTH(TILE_WIDTH)) u_ser (
    .clk         (clk),
    .rst         (rst),
    .load        (load_c),
    .tile_in     (bus.tile_in),
    .byte_cnt    (byte_cnt_q),
    .byte_c      (byte_c),
    .last_byte_c (last_byte_c)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      cur_addr_q   <= '0;
      bytes_left_q <= '0;
      byte_cnt_q   <= '0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_din_q    <= '0;
      valid_out_q  <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cur_addr_q   <= cur_addr_d;
      bytes_left_q <= bytes_left_d;
      byte_cnt_q   <= byte_cnt_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_din_q    <= mem_din_d;
      valid_out_q  <= valid_out_d;
      busy_q       <= busy_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cur_addr_d   = cur_addr_q;
    bytes_left_d = bytes_left_q;
    byte_cnt_d   = byte_cnt_q;
    mem_we_d     = 1'b0;
    mem_addr_d   = mem_addr_q;
    mem_din_d    = mem_din_q;
    valid_out_d  = 1'b0;
    load_c       = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.valid_in) begin
          cur_addr_d   = bus.dram_addr;
          bytes_left_d = bus.length;
          state_d      = (bus.length == '0) ? DONE : WAIT_TILE;
        end
      end
      WAIT_TILE: begin
        if (bus.tile_valid_in) begin
          load_c     = 1'b1;
          byte_cnt_d = '0;
          state_d    = WRITING;
        end
      end
      WRITING: begin
        mem_we_d     = 1'b1;
        mem_addr_d   = cur_addr_q;
        mem_din_d    = DATA_WIDTH'(byte_c);
        cur_addr_d   = cur_addr_q + ADDR_WIDTH'(1);
        bytes_left_d = bytes_left_q - LENGTH_WIDTH'(1);
        byte_cnt_d   = (NUM_BYTES == 1) ? '0 : byte_cnt_q + CNT_W'(1);
        if (bytes_left_q == LENGTH_WIDTH'(1)) begin
          state_d = DONE;
        end else if (last_byte_c) begin
          state_d = WAIT_TILE;
        end
      end
      DONE: begin
        valid_out_d = 1'b1;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Busy covers every non-idle state and the completion-pulse cycle.
    busy_d = (state_d != IDLE) || valid_out_d;
  end

  assign bus.tile_ready = (state_q == WAIT_TILE);
  assign bus.mem_we     = mem_we_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_din    = mem_din_q;
  assign bus.valid_out  = valid_out_q;
  assign bus.busy       = busy_q;

endmodule

// File: tb/tb_store_m.sv
// Randomized bench for store_m: byte-stream reference model plus pinned literal cases.
module tb_store_m;
  import tinyml_pkg::*;

  localparam int unsigned TW = 32;
  localparam int unsigned NB = TW / 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  store_m_if #(.TILE_WIDTH(TW)) bus ();

  store_m #(.TILE_WIDTH(TW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  typedef struct packed {
    logic [23:0] a;
    logic [7:0]  d;
  } wr_t;

  wr_t        exp_q[$];
  logic [7:0] mem[logic [23:0]];
  int errors = 0, checks = 0;
  int strobes = 0, done_cnt = 0, handshakes = 0, cyc = 0, last_we_cyc = 0;
  bit pending_nonzero = 0, drop_next = 0, rdy_seen = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: byte i of the store goes to base+i (mod 2^24) from tile i/NB, lane i%NB from the top.
  task automatic expect_stream(input logic [23:0] a, input int unsigned l, input logic [TW-1:0] tl[$]);
    wr_t e;
    for (int unsigned i = 0; i < l; i++) begin
      e.a = a + 24'(i);
      e.d = 8'(tl[i / NB] >> (8 * (NB - 1 - (i % NB))));
      exp_q.push_back(e);
    end
    pending_nonzero = (l != 0);
  endtask

  // Output monitor: every strobe must match the next reference byte.
  always begin : monitor
    wr_t e;
    @(posedge clk);
    #1;
    cyc++;
    if (rst) begin
      drop_next = 0;
    end else begin
      if (bus.tile_ready) rdy_seen = 1;
      if (bus.mem_we) begin
        strobes++;
        last_we_cyc = cyc;
        mem[bus.mem_addr] = bus.mem_din;
        chk("strobe_has_expectation", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("wr_addr", 32'(bus.mem_addr), 32'(e.a));
          chk("wr_data", 32'(bus.mem_din), 32'(e.d));
        end
      end
      if (bus.valid_out) begin
        chk("writes_drained_at_done", 32'(exp_q.size()), 32'd0);
        chk("busy_with_valid_out", 32'(bus.busy), 32'd1);
        if (pending_nonzero) chk("done_lag_after_last_write", 32'(cyc - last_we_cyc), 32'd1);
        done_cnt++;
        drop_next = 1;
      end else if (drop_next) begin
        chk("busy_drop_after_done", 32'(bus.busy), 32'd0);
        chk("ready_low_after_done", 32'(bus.tile_ready), 32'd0);
        drop_next = 0;
      end
    end
  end

  task automatic start(input logic [23:0] a, input logic [19:0] l);
    @(negedge clk);
    bus.valid_in  = 1'b1;
    bus.dram_addr = a;
    bus.length    = l;
    @(negedge clk);
    bus.valid_in  = 1'b0;
    bus.dram_addr = 24'($urandom);
    bus.length    = 20'($urandom);
  endtask

  task automatic feed(input logic [TW-1:0] tile, input int unsigned gap, input bit spurious);
    int n;
    bus.tile_valid_in = 1'b0;
    repeat (gap) begin
      bus.tile_in = TW'($urandom);
      @(negedge clk);
    end
    bus.tile_in       = tile;
    bus.tile_valid_in = 1'b1;
    n = 0;
    while (!bus.tile_ready && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("tile_ready_within_budget", 32'(n < 500), 32'd1);
    @(negedge clk);
    handshakes++;
    bus.tile_valid_in = 1'b0;
    bus.tile_in       = TW'($urandom);
    if (spurious) begin
      bus.valid_in  = 1'b1;
      bus.dram_addr = 24'($urandom);
      bus.length    = 20'($urandom_range(1, 50));
      @(negedge clk);
      bus.valid_in  = 1'b0;
    end
  endtask

  task automatic wait_done(input int d0);
    int n;
    n = 0;
    while (done_cnt == d0 && n < 2000) begin
      @(posedge clk);
      #2;
      n++;
    end
    chk("done_within_budget", 32'(done_cnt != d0), 32'd1);
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic run_op(input logic [23:0] a, input int unsigned l, input logic [TW-1:0] tl[$],
                        input bit spurious);
    int d0;
    int unsigned nt;
    nt = (l + NB - 1) / NB;
    expect_stream(a, l, tl);
    d0 = done_cnt;
    start(a, 20'(l));
    chk("busy_after_start", 32'(bus.busy), 32'd1);
    for (int unsigned t = 0; t < nt; t++) feed(tl[t], $urandom_range(0, 3), spurious && (t == 0));
    wait_done(d0);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time budget exhausted");
    $fatal(1);
  end

  initial begin : main
    logic [TW-1:0] tl[$];
    logic [TW-1:0] rb;
    logic [23:0]   a;
    int unsigned   l;
    int            s0, h0, d0;

    bus.valid_in      = 1'b0;
    bus.dram_addr     = '0;
    bus.length        = '0;
    bus.tile_in       = '0;
    bus.tile_valid_in = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_mem_we", 32'(bus.mem_we), 32'd0);
    chk("reset_busy", 32'(bus.busy), 32'd0);
    chk("reset_valid_out", 32'(bus.valid_out), 32'd0);
    chk("reset_tile_ready", 32'(bus.tile_ready), 32'd0);
    chk("reset_mem_addr", 32'(bus.mem_addr), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Single full tile
    s0 = strobes;
    tl = '{32'hAABBCCDD};
    run_op(24'h000100, 4, tl, 1'b0);
    chk("full_strobes", 32'(strobes - s0), 32'd4);
    chk("full_b0", 32'(mem[24'h000100]), 32'hAA);
    chk("full_b1", 32'(mem[24'h000101]), 32'hBB);
    chk("full_b2", 32'(mem[24'h000102]), 32'hCC);
    chk("full_b3", 32'(mem[24'h000103]), 32'hDD);

    // Partial final tile: padding bytes never reach memory
    mem[24'h000306] = 8'h5A;
    mem[24'h000307] = 8'h5A;
    s0 = strobes;
    tl = '{32'h01020304, 32'h0506FFFF};
    run_op(24'h000300, 6, tl, 1'b1);
    chk("partial_strobes", 32'(strobes - s0), 32'd6);
    for (int i = 0; i < 6; i++) chk("partial_byte", 32'(mem[24'h000300 + 24'(i)]), 32'(i + 1));
    chk("partial_pad6", 32'(mem[24'h000306]), 32'h5A);
    chk("partial_pad7", 32'(mem[24'h000307]), 32'h5A);

    // Backpressure: waiting for a tile produces no writes
    tl = '{32'h11223344};
    expect_stream(24'h000400, 4, tl);
    d0 = done_cnt;
    s0 = strobes;
    start(24'h000400, 20'd4);
    repeat (10) begin
      chk("bp_tile_ready", 32'(bus.tile_ready), 32'd1);
      chk("bp_no_strobe", 32'(bus.mem_we), 32'd0);
      @(negedge clk);
    end
    chk("bp_no_strobes_total", 32'(strobes - s0), 32'd0);
    feed(tl[0], 0, 1'b0);
    wait_done(d0);
    chk("bp_b3", 32'(mem[24'h000403]), 32'h44);

    // Zero length: completion two cycles after start, never ready
    rdy_seen = 0;
    s0 = strobes;
    pending_nonzero = 0;
    d0 = done_cnt;
    start(24'h000500, 20'd0);
    chk("zero_valid_out_early", 32'(bus.valid_out), 32'd0);
    @(posedge clk);
    #1;
    chk("zero_valid_out", 32'(bus.valid_out), 32'd1);
    wait_done(d0);
    chk("zero_no_strobes", 32'(strobes - s0), 32'd0);
    chk("zero_never_ready", 32'(rdy_seen), 32'd0);

    // Address wrap
    tl = '{32'h99887766};
    run_op(24'hFFFFFE, 4, tl, 1'b0);
    chk("wrap_fffffe", 32'(mem[24'hFFFFFE]), 32'h99);
    chk("wrap_ffffff", 32'(mem[24'hFFFFFF]), 32'h88);
    chk("wrap_000000", 32'(mem[24'h000000]), 32'h77);
    chk("wrap_000001", 32'(mem[24'h000001]), 32'h66);

    // Reset after the second strobe of a tile
    mem[24'h000202] = 8'h5A;
    mem[24'h000203] = 8'h5A;
    tl = '{32'hDEADBEEF};
    expect_stream(24'h000200, 4, tl);
    s0 = strobes;
    start(24'h000200, 20'd4);
    feed(tl[0], 1, 1'b0);
    h0 = 0;
    while (strobes < s0 + 2 && h0 < 50) begin
      @(posedge clk);
      #2;
      h0++;
    end
    rst = 1'b1;
    #1;
    chk("rst_mem_we", 32'(bus.mem_we), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_valid_out", 32'(bus.valid_out), 32'd0);
    chk("rst_tile_ready", 32'(bus.tile_ready), 32'd0);
    chk("rst_mem_din", 32'(bus.mem_din), 32'd0);
    exp_q.delete();
    repeat (3) begin
      @(negedge clk);
      chk("rst_held_no_we", 32'(bus.mem_we), 32'd0);
    end
    rst = 1'b0;
    @(negedge clk);
    chk("rst_strobes", 32'(strobes - s0), 32'd2);
    chk("rst_b0", 32'(mem[24'h000200]), 32'hDE);
    chk("rst_b2_untouched", 32'(mem[24'h000202]), 32'h5A);
    chk("rst_b3_untouched", 32'(mem[24'h000203]), 32'h5A);
    tl = '{32'hCAFEBABE};
    run_op(24'h000600, 4, tl, 1'b0);
    chk("post_rst_b0", 32'(mem[24'h000600]), 32'hCA);
    chk("post_rst_b3", 32'(mem[24'h000603]), 32'hBE);

    // Randomized operations, including near-wrap bases and ignored restarts
    for (int k = 0; k < 25; k++) begin
      l = $urandom_range(0, 13);
      if ($urandom_range(0, 3) == 0) a = 24'hFFFFF8 + 24'($urandom_range(0, 7));
      else a = 24'($urandom);
      tl.delete();
      for (int unsigned t = 0; t < (l + NB - 1) / NB; t++) tl.push_back(TW'($urandom));
      s0 = strobes;
      run_op(a, l, tl, $urandom_range(0, 1) == 1);
      chk("rand_strobes", 32'(strobes - s0), 32'(l));
    end

    // Long store: 100 bytes, read back as tiles
    tl.delete();
    for (int t = 0; t < 25; t++) tl.push_back(TW'($urandom));
    s0 = strobes;
    h0 = handshakes;
    run_op(24'h001000, 100, tl, 1'b0);
    chk("long_strobes", 32'(strobes - s0), 32'd100);
    chk("long_handshakes", 32'(handshakes - h0), 32'd25);
    for (int t = 0; t < 25; t++) begin
      for (int k = 0; k < int'(NB); k++) rb[TW-1-8*k -: 8] = mem[24'h001000 + 24'(t * int'(NB) + k)];
      chk("long_readback_tile", rb, tl[t]);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
